// File: rtl/tbus_owner_ctl_if.sv
// Request/grant and driver-pin bundle between requesters, the ownership controller and the invz bank.
interface tbus_owner_ctl_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
);
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   REQ;
  logic [NREQ*W-1:0] DIN;
  logic [NREQ-1:0]   GNT;
  logic [NREQ-1:0]   EN;
  logic [NREQ*W-1:0] I;
  logic              BUSY;
  logic [OW-1:0]     OWNER;

  modport master (
    input  REQ, DIN,
    output GNT, EN, I, BUSY, OWNER
  );

  modport slave (
    output REQ, DIN,
    input  GNT, EN, I, BUSY, OWNER
  );
endinterface

// File: rtl/tbus_owner_ctl.sv
// Round-robin owner of a shared invz tristate bus: one enable at a time, break-before-make
// turnaround, and pre-inverted driver data so the bus carries the true value.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no bank enabled, arbitrating from the priority pointer
// S_DRIVE | exactly one bank enabled, tenure counter running
// S_TURN  | all banks off for TURN cycles before the next arbitration
module tbus_owner_ctl #(
  parameter int NREQ    = 4,
  parameter int W       = 8,
  parameter int TURN    = 1,
  parameter int MAXHOLD = 16
) (
  input logic               CLK,
  input logic               RN,
  tbus_owner_ctl_if.master  bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = $clog2(MAXHOLD + 1);
  localparam int TW = $clog2(TURN + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_TURN  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [HW-1:0]     ten_q, ten_d;
  logic [TW-1:0]     turn_q, turn_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ*W-1:0] i_q, i_d;

  logic [PW-1:0]     cand;
  logic [PW-1:0]     pick_idx;
  logic              pick_vld;
  logic [NREQ-1:0]   others;
  logic              owner_req;
  logic              force_rel;

  // Descending offset scan so the slot closest to the pointer is the last (winning) assignment.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      cand = PW'((int'(ptr_q) + j) % NREQ);
      if (bus.REQ[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    others          = bus.REQ;
    others[owner_q] = 1'b0;
    owner_req       = bus.REQ[owner_q];
    force_rel       = (ten_q == HW'(MAXHOLD - 1)) && (|others);
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    ten_d   = ten_q;
    turn_d  = turn_q;
    gnt_d   = gnt_q;
    i_d     = i_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d                 = S_DRIVE;
          owner_d                 = pick_idx;
          gnt_d                   = '0;
          gnt_d[pick_idx]         = 1'b1;
          ten_d                   = '0;
          // Loaded on the same edge that raises EN so no stale data reaches the bus.
          i_d[pick_idx*W +: W]    = ~bus.DIN[pick_idx*W +: W];
        end
      end
      S_DRIVE: begin
        i_d[owner_q*W +: W] = ~bus.DIN[owner_q*W +: W];
        if (!owner_req || force_rel) begin
          state_d = S_TURN;
          gnt_d   = '0;
          turn_d  = '0;
          ptr_d   = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        end else if (ten_q != HW'(MAXHOLD)) begin
          ten_d = ten_q + 1'b1;
        end
      end
      S_TURN: begin
        if (turn_q == TW'(TURN - 1)) begin
          state_d = S_IDLE;
        end else begin
          turn_d = turn_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      ten_q   <= '0;
      turn_q  <= '0;
      gnt_q   <= '0;
      i_q     <= '1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      ten_q   <= ten_d;
      turn_q  <= turn_d;
      gnt_q   <= gnt_d;
      i_q     <= i_d;
    end
  end

  assign bus.GNT   = gnt_q;
  assign bus.EN    = gnt_q;
  assign bus.I     = i_q;
  assign bus.BUSY  = (state_q != S_IDLE);
  assign bus.OWNER = owner_q;

endmodule

// File: tb/tb_tbus_owner_ctl.sv
// Bench for tbus_owner_ctl: grant-event scoreboard (slot, data, tenure, gap) plus per-cycle invariants.
module tb_tbus_owner_ctl;
  localparam int NREQ    = 4;
  localparam int W       = 8;
  localparam int TURN    = 1;
  localparam int MAXHOLD = 4;

  logic CLK = 1'b0;
  logic RN;

  initial forever #5 CLK = ~CLK;

  tbus_owner_ctl_if #(.NREQ(NREQ), .W(W)) bus_if ();

  tbus_owner_ctl #(
    .NREQ(NREQ), .W(W), .TURN(TURN), .MAXHOLD(MAXHOLD)
  ) u_dut (
    .CLK (CLK),
    .RN  (RN),
    .bus (bus_if)
  );

  typedef struct {
    int         slot;
    int         len;
    int         gap;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e_cur;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] din_v [NREQ] = '{8'h81, 8'h3C, 8'hA5, 8'h96};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic apply_din();
    for (int k = 0; k < NREQ; k++) bus_if.DIN[k*W +: W] = din_v[k];
  endtask

  task automatic push(input int slot, input int len, input int gap);
    exp_t e;
    e.slot = slot;
    e.len  = len;
    e.gap  = gap;
    e.data = ~din_v[slot];
    exp_q.push_back(e);
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge CLK);
      #1;
    end
    chk(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic rst_on();
    @(negedge CLK);
    RN = 1'b0;
    @(negedge CLK);
  endtask

  task automatic rst_off();
    @(negedge CLK);
    RN = 1'b1;
  endtask

  // Grant monitor: a rising EN pops the next expected owner; tenure and gap are counted in cycles.
  logic [NREQ-1:0] prev_en = '0;
  int tlen = 0, glen = 0, cur_len = -1;

  initial forever begin
    @(negedge CLK);
    if (!RN) begin
      prev_en = '0;
      tlen    = 0;
      glen    = 0;
      cur_len = -1;
    end else begin
      chk("en_eq_gnt", bus_if.EN, bus_if.GNT);
      chk("en_onehot0", {31'd0, ($countones(bus_if.EN) <= 1)}, 32'd1);
      if (bus_if.EN != '0) chk("busy_when_en", bus_if.BUSY, 1);
      if (bus_if.EN != '0 && prev_en == '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", bus_if.EN, 0);
          cur_len = -1;
        end else begin
          e_cur = exp_q.pop_front();
          chk("grant_en", bus_if.EN, 32'd1 << e_cur.slot);
          chk("owner", bus_if.OWNER, e_cur.slot);
          chk("drive_data", bus_if.I[e_cur.slot*W +: W], e_cur.data);
          if (e_cur.gap >= 0) chk("gap_len", glen, e_cur.gap);
          cur_len = e_cur.len;
        end
        tlen = 1;
      end else if (bus_if.EN != '0 && bus_if.EN == prev_en) begin
        tlen++;
      end else if (bus_if.EN != '0) begin
        chk("break_before_make", bus_if.EN, prev_en);
      end else if (prev_en != '0) begin
        if (cur_len >= 0) chk("tenure_len", tlen, cur_len);
        glen = 1;
      end else begin
        glen++;
      end
      prev_en = bus_if.EN;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, n_cmp %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    RN         = 1'b0;
    bus_if.REQ = 4'b1111;
    bus_if.DIN = '0;
    apply_din();

    // Reset state with everyone requesting
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_en", bus_if.EN, 0);
    chk("rst_gnt", bus_if.GNT, 0);
    chk("rst_i", bus_if.I, 32'hFFFF_FFFF);
    chk("rst_busy", bus_if.BUSY, 0);
    chk("rst_owner", bus_if.OWNER, 0);

    // Round-robin wrap 0,1,2,3,0 with forced release at MAXHOLD
    push(0, MAXHOLD, -1);
    push(1, MAXHOLD, TURN + 1);
    push(2, MAXHOLD, TURN + 1);
    push(3, MAXHOLD, TURN + 1);
    push(0, -1, TURN + 1);
    rst_off();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1;
    chk("rst_release_en", bus_if.EN, 4'b0001);
    drain("drain_rr", 80);
    bus_if.REQ = '0;
    repeat (4) @(negedge CLK);

    // Forced release between slots 0 and 3
    rst_on();
    bus_if.REQ = 4'b1001;
    push(0, MAXHOLD, -1);
    push(3, MAXHOLD, TURN + 1);
    push(0, -1, TURN + 1);
    rst_off();
    drain("drain_forced", 40);
    bus_if.REQ = '0;
    repeat (4) @(negedge CLK);

    // Handover 0 -> 1 with slot 0 dropping after 3 cycles
    rst_on();
    bus_if.REQ = 4'b0011;
    push(0, 3, -1);
    push(1, -1, TURN + 1);
    rst_off();
    repeat (3) @(negedge CLK);
    bus_if.REQ = 4'b0010;
    drain("drain_handover", 20);
    bus_if.REQ = '0;
    repeat (4) @(negedge CLK);

    // Single owner on slot 2 for 5 cycles, data tracking while driving
    push(2, 5, -1);
    bus_if.REQ = 4'b0100;
    repeat (2) @(negedge CLK);
    #1;
    chk("single_owner", bus_if.OWNER, 2);
    chk("single_busy", bus_if.BUSY, 1);
    chk("idle_slot_i", bus_if.I[3*W +: W], 8'hFF);
    din_v[2] = 8'h0F;
    apply_din();
    @(negedge CLK);
    #1;
    chk("data_follow", bus_if.I[2*W +: W], 8'hF0);
    repeat (2) @(negedge CLK);
    bus_if.REQ = '0;
    din_v[2]   = 8'hA5;
    apply_din();
    drain("drain_single", 5);
    repeat (4) @(negedge CLK);

    // Reset mid-tenure: EN drops without a clock, pointer restarts at 0
    push(2, -1, -1);
    bus_if.REQ = 4'b0100;
    repeat (3) @(negedge CLK);
    #1;
    chk("pre_rst_en", bus_if.EN, 4'b0100);
    #1;
    RN = 1'b0;
    #1;
    chk("rst_async_en", bus_if.EN, 0);
    chk("rst_async_busy", bus_if.BUSY, 0);
    chk("rst_async_owner", bus_if.OWNER, 0);
    chk("rst_async_i", bus_if.I[2*W +: W], 8'hFF);
    bus_if.REQ = 4'b1001;
    push(0, -1, -1);
    @(negedge CLK);
    @(negedge CLK);
    RN = 1'b1;
    drain("drain_rst_mid", 10);
    bus_if.REQ = '0;
    repeat (4) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
